// File: rtl/seq_pkg.sv
// Shared types and widths for the per-sample conversion sequencer.
// The state encoding is fixed at 3 bits so it can be observed on debug buses.
package seq_pkg;

    localparam int SIG_W    = 16;
    localparam int DOUBLE_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONV_IN   = 3'd1,
        ST_WAIT_CONV = 3'd2,
        ST_PROC      = 3'd3,
        ST_WAIT_PROC = 3'd4,
        ST_CONV_OUT  = 3'd5
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Shared down-counter used for enable pulse widths and handshake watchdogs.
// Loading with limit L makes terminal assert in the L-th enabled cycle after the load.
module seq_watchdog #(
    parameter int W = 11
) (
    input  logic         clk_operation,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         terminal
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = limit - W'(1);
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Terminal depends only on the registered count so the FSM can use it
    // to choose the next state (which in turn drives clear) without a loop.
    assign terminal = enable && (count_q == '0);

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sample_conv_sequencer.sv
// Per-sample sequencer: 16-bit sample -> converter -> echo-cancel core -> output converter.
// One FSM plus datapath holding registers; one watchdog counter shared by all timed states.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for sample_tick
// ST_CONV_IN   | conv_enable high for ENABLE_WIDTH cycles
// ST_WAIT_CONV | waiting for conv_ready, CONV_TIMEOUT watchdog
// ST_PROC      | one-cycle proc_start
// ST_WAIT_PROC | waiting for proc_done, PROC_TIMEOUT watchdog
// ST_CONV_OUT  | out_enable high for ENABLE_WIDTH cycles, frame counted in last
module sample_conv_sequencer
    import seq_pkg::*;
#(
    parameter int ENABLE_WIDTH = 5,
    parameter int CONV_TIMEOUT = 64,
    parameter int PROC_TIMEOUT = 1024,
    parameter int CNT_W        = 8
) (
    input  logic                clk_operation,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic [SIG_W-1:0]    sig16b_in,
    input  logic                bypass,
    output logic [SIG_W-1:0]    conv_sig16b,
    output logic                conv_enable,
    input  logic                conv_ready,
    input  logic [DOUBLE_W-1:0] conv_double,
    output logic                proc_start,
    output logic [DOUBLE_W-1:0] proc_double,
    input  logic                proc_done,
    input  logic [DOUBLE_W-1:0] proc_result,
    output logic [DOUBLE_W-1:0] out_double,
    output logic                out_enable,
    output logic                busy,
    output logic                err_timeout,
    output logic [CNT_W-1:0]    overrun_cnt,
    output logic [CNT_W-1:0]    frame_cnt
);

    localparam int WD_MAX = max3(ENABLE_WIDTH, CONV_TIMEOUT, PROC_TIMEOUT);
    localparam int WD_W   = $clog2(WD_MAX + 1);

    localparam logic [WD_W-1:0] LIM_EW   = WD_W'(ENABLE_WIDTH);
    localparam logic [WD_W-1:0] LIM_CONV = WD_W'(CONV_TIMEOUT);
    localparam logic [WD_W-1:0] LIM_PROC = WD_W'(PROC_TIMEOUT);

    seq_state_t          state_q,       state_d;
    logic [SIG_W-1:0]    conv_sig16b_q, conv_sig16b_d;
    logic                conv_enable_q, conv_enable_d;
    logic                proc_start_q,  proc_start_d;
    logic [DOUBLE_W-1:0] proc_double_q, proc_double_d;
    logic [DOUBLE_W-1:0] out_double_q,  out_double_d;
    logic                out_enable_q,  out_enable_d;
    logic                busy_q,        busy_d;
    logic                err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]    overrun_cnt_q, overrun_cnt_d;
    logic [CNT_W-1:0]    frame_cnt_q,   frame_cnt_d;

    logic            wd_clear;
    logic            wd_enable;
    logic [WD_W-1:0] wd_limit;
    logic            wd_term;

    seq_watchdog #(
        .W (WD_W)
    ) u_watchdog (
        .clk_operation (clk_operation),
        .rst           (rst),
        .clear         (wd_clear),
        .enable        (wd_enable),
        .limit         (wd_limit),
        .terminal      (wd_term)
    );

    always_comb begin
        state_d       = state_q;
        conv_sig16b_d = conv_sig16b_q;
        proc_double_d = proc_double_q;
        out_double_d  = out_double_q;
        err_timeout_d = err_timeout_q;
        overrun_cnt_d = overrun_cnt_q;
        frame_cnt_d   = frame_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    conv_sig16b_d = sig16b_in;
                    state_d       = ST_CONV_IN;
                end
            end
            ST_CONV_IN: begin
                if (wd_term) begin
                    state_d = ST_WAIT_CONV;
                end
            end
            ST_WAIT_CONV: begin
                // A handshake in the terminal cycle still wins over the abort.
                if (conv_ready) begin
                    if (bypass) begin
                        out_double_d = conv_double;
                        state_d      = ST_CONV_OUT;
                    end else begin
                        proc_double_d = conv_double;
                        state_d       = ST_PROC;
                    end
                end else if (wd_term) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_PROC: begin
                state_d = ST_WAIT_PROC;
            end
            ST_WAIT_PROC: begin
                if (proc_done) begin
                    out_double_d = proc_result;
                    state_d      = ST_CONV_OUT;
                end else if (wd_term) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_CONV_OUT: begin
                if (wd_term) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (sample_tick && (state_q != ST_IDLE) && (overrun_cnt_q != '1)) begin
            overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
        end

        // Strobes are registered from the next state so they line up with it.
        conv_enable_d = (state_d == ST_CONV_IN);
        proc_start_d  = (state_d == ST_PROC);
        out_enable_d  = (state_d == ST_CONV_OUT);
        busy_d        = (state_d != ST_IDLE);
    end

    always_comb begin
        wd_clear  = (state_d != state_q);
        wd_enable = (state_q == ST_CONV_IN)   || (state_q == ST_WAIT_CONV) ||
                    (state_q == ST_WAIT_PROC) || (state_q == ST_CONV_OUT);
        unique case (state_d)
            ST_WAIT_CONV: wd_limit = LIM_CONV;
            ST_WAIT_PROC: wd_limit = LIM_PROC;
            default:      wd_limit = LIM_EW;
        endcase
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            conv_sig16b_q <= '0;
            conv_enable_q <= 1'b0;
            proc_start_q  <= 1'b0;
            proc_double_q <= '0;
            out_double_q  <= '0;
            out_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_cnt_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            conv_sig16b_q <= conv_sig16b_d;
            conv_enable_q <= conv_enable_d;
            proc_start_q  <= proc_start_d;
            proc_double_q <= proc_double_d;
            out_double_q  <= out_double_d;
            out_enable_q  <= out_enable_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            overrun_cnt_q <= overrun_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign conv_sig16b = conv_sig16b_q;
    assign conv_enable = conv_enable_q;
    assign proc_start  = proc_start_q;
    assign proc_double = proc_double_q;
    assign out_double  = out_double_q;
    assign out_enable  = out_enable_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;
    assign overrun_cnt = overrun_cnt_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
